// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths, write-port priority and popcount helpers for
//               the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int POP_MAX_W  = 256;

  // Resolved write hit: any port hits, and whether port 1's data is the one used
  typedef struct packed {
    logic hit;
    logic use1;
  } wr_sel_t;

  // Port 1 takes priority over port 0 when both target the same entry
  function automatic wr_sel_t wr_sel(input logic hit0, input logic hit1);
    wr_sel_t s;
    s.hit  = hit0 | hit1;
    s.use1 = hit1;
    return s;
  endfunction

  // Number of set bits; callers zero-extend narrower vectors
  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int k = 0; k < POP_MAX_W; k++) begin
      cnt += 32'(vec[k]);
    end
    return cnt;
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port: address decode, write-to-read
//               bypass, zero-register mask and busy lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    mem [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_vec,
  input  logic                 byp_en,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    wr_addr0,
  input  logic [DATA_W-1:0]    wr_data0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    wr_addr1,
  input  logic [DATA_W-1:0]    wr_data1,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 busy
);

  wr_sel_t w_sel;
  logic    w_byp;
  logic    w_rsv_hit;
  logic    w_zero;

  assign w_sel     = wr_sel(byp_en && we0 && (wr_addr0 == rd_addr),
                            byp_en && we1 && (wr_addr1 == rd_addr));
  assign w_byp     = (BYPASS != 0) && w_sel.hit;
  assign w_rsv_hit = byp_en && rsv_en && (rsv_addr == rd_addr);
  assign w_zero    = (ZERO_REG != 0) && (rd_addr == '0);

  // Data select: zero register first, then in-flight write, then storage
  always_comb begin
    rd_data = mem[rd_addr];
    if (w_zero) begin
      rd_data = '0;
    end else if (w_byp) begin
      rd_data = w_sel.use1 ? wr_data1 : wr_data0;
    end
  end

  // Busy: a bypassed write retires the entry unless a new reserve lands alongside it
  always_comb begin
    busy = busy_vec[rd_addr];
    if (w_zero || (w_byp && !w_rsv_hit)) begin
      busy = 1'b0;
    end
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : 2-write / 2-read register file with per-entry busy
//               scoreboard and registered busy count.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_next;
  logic [DEPTH-1:0]  w_we;
  logic [DEPTH-1:0]  w_use1;
  logic [ADDR_W:0]   r_busy_cnt;

  // Per-entry write decode and scoreboard next state
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam bit IS_ZERO = (ZERO_REG != 0) && (i == 0);
    wr_sel_t w_sel;
    logic    w_rsv;

    assign w_sel     = wr_sel(we0 && (wr_addr0 == ADDR_W'(i)),
                              we1 && (wr_addr1 == ADDR_W'(i)));
    assign w_rsv     = rsv_en && (rsv_addr == ADDR_W'(i));
    assign w_we[i]   = w_sel.hit && !IS_ZERO;
    assign w_use1[i] = w_sel.use1;
    // Reserve outranks a retiring write: it belongs to a newer producer
    assign w_busy_next[i] = IS_ZERO ? 1'b0 :
                            w_rsv   ? 1'b1 :
                            w_sel.hit ? 1'b0 : r_busy[i];
  end

  // Storage array update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= w_use1[i] ? wr_data1 : wr_data0;
        end
      end
    end
  end

  // Busy vector and its count, both taken from the same next-state vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= (ADDR_W+1)'(popcount(POP_MAX_W'(w_busy_next)));
    end
  end

  assign busy_cnt = r_busy_cnt;

  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .rd_addr  (rd_addr1),
    .mem      (r_mem),
    .busy_vec (r_busy),
    .byp_en   (!rst),
    .we0      (we0),
    .wr_addr0 (wr_addr0),
    .wr_data0 (wr_data0),
    .we1      (we1),
    .wr_addr1 (wr_addr1),
    .wr_data1 (wr_data1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_data  (rd_data1),
    .busy     (busy1)
  );

  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .rd_addr  (rd_addr2),
    .mem      (r_mem),
    .busy_vec (r_busy),
    .byp_en   (!rst),
    .we0      (we0),
    .wr_addr0 (wr_addr0),
    .wr_data0 (wr_data0),
    .we1      (we1),
    .wr_addr1 (wr_addr1),
    .wr_data1 (wr_data1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_data  (rd_data2),
    .busy     (busy2)
  );

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp; three instances
//               share stimulus: bypass, no-bypass, bypass + zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic       clk;
  logic       rst;
  logic       we0, we1, rsv_en;
  logic [2:0] wr_addr0, wr_addr1, rd_addr1, rd_addr2, rsv_addr;
  logic [7:0] wr_data0, wr_data1;

  logic [7:0] rd1_a, rd2_a, rd1_n, rd2_n, rd1_z, rd2_z;
  logic       b1_a, b2_a, b1_n, b2_n, b1_z, b2_z;
  logic [3:0] cnt_a, cnt_n, cnt_z;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1(we1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_a), .rd_data2(rd2_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_a), .busy2(b2_a), .busy_cnt(cnt_a)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u_nb (
    .clk(clk), .rst(rst),
    .we0(we0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1(we1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_n), .rd_data2(rd2_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_n), .busy2(b2_n), .busy_cnt(cnt_n)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst),
    .we0(we0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1(we1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_z), .rd_data2(rd2_z),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_z), .busy2(b2_z), .busy_cnt(cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_addr1 = '0; rd_addr2 = '0; rsv_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", rd1_a, 0);
    chk("reset_cnt", cnt_a, 0);
    rst = 1'b0;

    // 1: fill with 0xA5, reserving entries 1..4 along the way
    for (int c = 0; c < 4; c++) begin
      we0 = 1'b1; wr_addr0 = 3'(2*c);   wr_data0 = 8'hA5;
      we1 = 1'b1; wr_addr1 = 3'(2*c+1); wr_data1 = 8'hA5;
      rsv_en = 1'b1; rsv_addr = 3'(c+1);
      step();
    end
    idle();
    rd_addr1 = 3'd7; rd_addr2 = 3'd1;
    #1;
    chk("fill_rd7", rd1_a, 8'hA5);
    chk("fill_busy1", b2_a, 1);
    chk("fill_cnt", cnt_a, 4);
    chk("fill_cnt_z", cnt_z, 4);
    // Mid-cycle reset with a write pending: everything must read 0 at once
    #2;
    rst = 1'b1;
    we0 = 1'b1; wr_addr0 = 3'd7; wr_data0 = 8'h55;
    #1;
    chk("rst_rd1", rd1_a, 0);
    chk("rst_rd2", rd2_a, 0);
    chk("rst_busy1", b1_a, 0);
    chk("rst_busy2", b2_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_rd1_nb", rd1_n, 0);
    chk("rst_cnt_z", cnt_z, 0);
    step();
    idle();
    rst = 1'b0;
    #1;
    chk("rst_wr_blocked", rd1_n, 0);

    // 2: write collision on addr3
    we0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 8'h11;
    we1 = 1'b1; wr_addr1 = 3'd3; wr_data1 = 8'h22;
    rd_addr1 = 3'd3; rd_addr2 = 3'd3;
    #1;
    chk("coll_byp", rd1_a, 8'h22);
    chk("coll_nobyp", rd1_n, 8'h00);
    step();
    idle();
    #1;
    chk("coll_stored", rd1_a, 8'h22);
    chk("coll_stored_nb", rd2_n, 8'h22);
    // Single-port bypass on read port 2
    we0 = 1'b1; wr_addr0 = 3'd4; wr_data0 = 8'h44; rd_addr2 = 3'd4;
    #1;
    chk("p0_byp_rd2", rd2_a, 8'h44);
    chk("p0_nobyp_rd2", rd2_n, 8'h00);
    step();
    idle();
    #1;
    chk("p0_stored_rd2", rd2_n, 8'h44);

    // 3: reserve then retire addr5
    rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr1 = 3'd5;
    #1;
    chk("rsv_same_cycle", b1_a, 0);
    step();
    idle();
    #1;
    chk("rsv_busy", b1_a, 1);
    chk("rsv_cnt", cnt_a, 1);
    we0 = 1'b1; wr_addr0 = 3'd5; wr_data0 = 8'h3C;
    #1;
    chk("ret_byp_busy", b1_a, 0);
    chk("ret_nobyp_busy", b1_n, 1);
    chk("ret_byp_data", rd1_a, 8'h3C);
    step();
    idle();
    #1;
    chk("ret_busy", b1_n, 0);
    chk("ret_cnt", cnt_a, 0);
    chk("ret_data", rd1_n, 8'h3C);

    // 4: reserve and write addr2 together
    rsv_en = 1'b1; rsv_addr = 3'd2;
    we1 = 1'b1; wr_addr1 = 3'd2; wr_data1 = 8'h77;
    rd_addr1 = 3'd2;
    #1;
    chk("rw_same_busy", b1_a, 0);
    step();
    idle();
    #1;
    chk("rw_busy", b1_a, 1);
    chk("rw_data", rd1_n, 8'h77);
    chk("rw_cnt", cnt_a, 1);
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step();
    idle();
    #1;
    chk("rersv_cnt", cnt_a, 1);
    chk("rersv_busy", b1_n, 1);
    we0 = 1'b1; wr_addr0 = 3'd2; wr_data0 = 8'h78;
    step();
    idle();
    #1;
    chk("rw_clear_cnt", cnt_a, 0);

    // 5: zero register
    we0 = 1'b1; wr_addr0 = 3'd0; wr_data0 = 8'hFF;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    #1;
    chk("zr_byp_rd", rd1_z, 0);
    chk("zr_byp_busy", b1_z, 0);
    chk("nz_byp_rd", rd1_a, 8'hFF);
    step();
    idle();
    #1;
    chk("zr_rd", rd2_z, 0);
    chk("zr_busy", b2_z, 0);
    chk("zr_cnt", cnt_z, 0);
    chk("nz_rd", rd1_n, 8'hFF);
    chk("nz_cnt", cnt_a, 1);
    we1 = 1'b1; wr_addr1 = 3'd0; wr_data1 = 8'h01;
    step();
    idle();
    #1;
    chk("nz_clear_cnt", cnt_a, 0);

    // 6: reserve every entry, then retire them all
    for (int k = 0; k < 8; k++) begin
      rsv_en = 1'b1; rsv_addr = 3'(k);
      step();
    end
    idle();
    rd_addr1 = 3'd7;
    #1;
    chk("full_cnt", cnt_a, 8);
    chk("full_cnt_z", cnt_z, 7);
    chk("full_busy7", b1_n, 1);
    for (int c = 0; c < 4; c++) begin
      we0 = 1'b1; wr_addr0 = 3'(2*c);   wr_data0 = 8'(c);
      we1 = 1'b1; wr_addr1 = 3'(2*c+1); wr_data1 = 8'(c + 8'h10);
      step();
      if (c == 1) chk("drain_half_cnt", cnt_a, 4);
    end
    idle();
    #1;
    chk("drain_cnt", cnt_a, 0);
    chk("drain_cnt_z", cnt_z, 0);
    // Retiring an idle entry must not underflow
    we0 = 1'b1; wr_addr0 = 3'd6; wr_data0 = 8'h66;
    step();
    idle();
    #1;
    chk("no_underflow", cnt_a, 0);
    chk("drain_data7", rd1_n, 8'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_mp
`default_nettype wire
